// File: rtl/barrel_normalizer_pkg.sv
// Shared ALU definitions for the normalizer: FSM encoding, shift-direction
// encoding (matching the barrel shifter) and default datapath sizes.
package barrel_normalizer_pkg;

    localparam int NORM_WIDTH = 32;
    localparam int NORM_SW    = 5;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } norm_state_e;

endpackage

// File: rtl/barrel_normalizer_norm_step.sv
// One binary normalization stage: if the 2^k-bit window at the normalizing
// end is all zero, shift it out (zero fill) and report a hit.
module barrel_normalizer_norm_step
    import barrel_normalizer_pkg::*;
#(
    parameter int WIDTH = NORM_WIDTH,
    parameter int SW    = NORM_SW
) (
    input  logic [WIDTH-1:0] w,
    input  logic             dir,
    input  logic [SW-1:0]    k,
    output logic [WIDTH-1:0] w_next,
    output logic             hit
);

    logic [WIDTH-1:0] size_s;
    logic [WIDTH-1:0] mask_s;

    // Window mask selection, zero test and conditional logical shift.
    always_comb begin
        size_s = {{(WIDTH-1){1'b0}}, 1'b1} << k;
        if (dir == DIR_LEFT) begin
            mask_s = ~({WIDTH{1'b1}} >> size_s);
        end else begin
            mask_s = ~({WIDTH{1'b1}} << size_s);
        end
        hit = ((w & mask_s) == {WIDTH{1'b0}});
        if (!hit) begin
            w_next = w;
        end else if (dir == DIR_LEFT) begin
            w_next = w << size_s;
        end else begin
            w_next = w >> size_s;
        end
    end

endmodule

// File: rtl/barrel_normalizer.sv
// Multi-cycle normalizer (count leading/trailing zeros) resolving one binary
// stage per clock with a start/busy/done handshake; results are registered.
module barrel_normalizer
    import barrel_normalizer_pkg::*;
#(
    parameter int WIDTH = NORM_WIDTH,
    parameter int SW    = NORM_SW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] i,
    input  logic             dir,
    output logic [WIDTH-1:0] o,
    output logic [SW-1:0]    shamt,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    norm_state_e      state_r, state_n;
    logic [SW-1:0]    k_r, k_n;
    logic [WIDTH-1:0] w_r, w_n;
    logic [SW-1:0]    c_r, c_n;
    logic             dir_r, dir_n;
    logic [WIDTH-1:0] o_r, o_n;
    logic [SW-1:0]    shamt_r, shamt_n;
    logic             zero_r, zero_n;
    logic             busy_r, busy_n;
    logic             done_r, done_n;

    logic [WIDTH-1:0] step_w_s;
    logic             step_hit_s;

    barrel_normalizer_norm_step #(
        .WIDTH (WIDTH),
        .SW    (SW)
    ) u_step (
        .w      (w_r),
        .dir    (dir_r),
        .k      (k_r),
        .w_next (step_w_s),
        .hit    (step_hit_s)
    );

    // State, working and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            k_r     <= {SW{1'b0}};
            w_r     <= {WIDTH{1'b0}};
            c_r     <= {SW{1'b0}};
            dir_r   <= DIR_LEFT;
            o_r     <= {WIDTH{1'b0}};
            shamt_r <= {SW{1'b0}};
            zero_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            k_r     <= k_n;
            w_r     <= w_n;
            c_r     <= c_n;
            dir_r   <= dir_n;
            o_r     <= o_n;
            shamt_r <= shamt_n;
            zero_r  <= zero_n;
            busy_r  <= busy_n;
            done_r  <= done_n;
        end
    end

    // Next-state and datapath control; outputs only move on the k=0 stage.
    always_comb begin
        state_n = state_r;
        k_n     = k_r;
        w_n     = w_r;
        c_n     = c_r;
        dir_n   = dir_r;
        o_n     = o_r;
        shamt_n = shamt_r;
        zero_n  = zero_r;
        busy_n  = busy_r;
        done_n  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    w_n     = i;
                    dir_n   = dir;
                    c_n     = {SW{1'b0}};
                    k_n     = SW'(SW - 1);
                    busy_n  = 1'b1;
                    state_n = ST_RUN;
                end else begin
                    busy_n  = 1'b0;
                end
            end
            ST_RUN: begin
                w_n = step_w_s;
                c_n = c_r | ({{(SW-1){1'b0}}, step_hit_s} << k_r);
                if (k_r == {SW{1'b0}}) begin
                    // A nonzero operand never shifts out a one, so a zero
                    // final word means the operand itself was zero.
                    o_n     = step_w_s;
                    shamt_n = c_n;
                    zero_n  = (step_w_s == {WIDTH{1'b0}});
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = ST_IDLE;
                end else begin
                    k_n = k_r - {{(SW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign o     = o_r;
    assign shamt = shamt_r;
    assign zero  = zero_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_barrel_normalizer.sv
// Directed and random self-checking bench for barrel_normalizer.
module tb_barrel_normalizer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] i;
    logic        dir;
    logic [31:0] o;
    logic [4:0]  shamt;
    logic        zero;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    barrel_normalizer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .i     (i),
        .dir   (dir),
        .o     (o),
        .shamt (shamt),
        .zero  (zero),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_cnt(input logic [31:0] a, input logic d);
        if (a == 32'h0) return 31;
        for (int b = 0; b < 32; b++) begin
            if (d == 1'b0 ? a[31-b] : a[b]) return b;
        end
        return 31;
    endfunction

    // Issue one operation and wait (bounded) for DONE; DIR is flipped after
    // acceptance so the latched direction must be used.
    task automatic do_op(input logic [31:0] a, input logic d, output int lat,
                         output int busy_cnt, output logic [31:0] ro,
                         output logic [4:0] rs, output logic rz);
        @(posedge clk); #1;
        i = a; dir = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; dir = ~d; i = 32'hDEAD_BEEF;
        lat = 0; busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        ro = o; rs = shamt; rz = zero;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; i = 32'h0; dir = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (o !== 32'h0) begin n_bad++; $display("FAIL reset_o: got %h want 0", o); end
        n_cmp++; if (shamt !== 5'd0) begin n_bad++; $display("FAIL reset_shamt: got %0d want 0", shamt); end
        n_cmp++; if ({zero, busy, done} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {zero, busy, done}); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_left_normalize();
        logic [31:0] vi [3];
        logic [31:0] vo [3];
        logic [4:0]  vs [3];
        int lat, bc; logic [31:0] ro; logic [4:0] rs; logic rz;
        vi = '{32'h0000_0100, 32'h0000_0001, 32'h0003_0000};
        vo = '{32'h8000_0000, 32'h8000_0000, 32'hC000_0000};
        vs = '{5'd23, 5'd31, 5'd14};
        for (int j = 0; j < 3; j++) begin
            do_op(vi[j], 1'b0, lat, bc, ro, rs, rz);
            n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL left_lat[%0d]: got %0d want 5", j, lat); end
            n_cmp++; if (bc !== 5) begin n_bad++; $display("FAIL left_busy[%0d]: got %0d cycles want 5", j, bc); end
            n_cmp++; if (ro !== vo[j]) begin n_bad++; $display("FAIL left_o[%0d]: got %h want %h", j, ro, vo[j]); end
            n_cmp++; if (rs !== vs[j]) begin n_bad++; $display("FAIL left_shamt[%0d]: got %0d want %0d", j, rs, vs[j]); end
            n_cmp++; if (rz !== 1'b0) begin n_bad++; $display("FAIL left_zero[%0d]: got %b want 0", j, rz); end
            @(posedge clk); #1;
            n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL left_done_pulse[%0d]: got %b want 0", j, done); end
        end
    endtask

    task automatic test_right_normalize();
        logic [31:0] vi [3];
        logic [31:0] vo [3];
        logic [4:0]  vs [3];
        int lat, bc; logic [31:0] ro; logic [4:0] rs; logic rz;
        vi = '{32'h0000_0100, 32'h8000_0000, 32'h00F0_0000};
        vo = '{32'h0000_0001, 32'h0000_0001, 32'h0000_000F};
        vs = '{5'd8, 5'd31, 5'd20};
        for (int j = 0; j < 3; j++) begin
            do_op(vi[j], 1'b1, lat, bc, ro, rs, rz);
            n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL right_lat[%0d]: got %0d want 5", j, lat); end
            n_cmp++; if (ro !== vo[j]) begin n_bad++; $display("FAIL right_o[%0d]: got %h want %h", j, ro, vo[j]); end
            n_cmp++; if (rs !== vs[j]) begin n_bad++; $display("FAIL right_shamt[%0d]: got %0d want %0d", j, rs, vs[j]); end
            n_cmp++; if (rz !== 1'b0) begin n_bad++; $display("FAIL right_zero[%0d]: got %b want 0", j, rz); end
        end
    endtask

    task automatic test_zero_operand();
        int lat, bc; logic [31:0] ro; logic [4:0] rs; logic rz;
        for (int j = 0; j < 2; j++) begin
            do_op(32'h0, j[0], lat, bc, ro, rs, rz);
            n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL zero_lat[%0d]: got %0d want 5", j, lat); end
            n_cmp++; if (ro !== 32'h0) begin n_bad++; $display("FAIL zero_o[%0d]: got %h want 0", j, ro); end
            n_cmp++; if (rs !== 5'd31) begin n_bad++; $display("FAIL zero_shamt[%0d]: got %0d want 31", j, rs); end
            n_cmp++; if (rz !== 1'b1) begin n_bad++; $display("FAIL zero_flag[%0d]: got %b want 1", j, rz); end
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] vi [4];
        logic        vd [4];
        int lat, bc; logic [31:0] ro; logic [4:0] rs; logic rz;
        vi = '{32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vd = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int j = 0; j < 4; j++) begin
            do_op(vi[j], vd[j], lat, bc, ro, rs, rz);
            n_cmp++; if (rs !== 5'd0) begin n_bad++; $display("FAIL bound_shamt[%0d]: got %0d want 0", j, rs); end
            n_cmp++; if (ro !== vi[j]) begin n_bad++; $display("FAIL bound_o[%0d]: got %h want %h", j, ro, vi[j]); end
            n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL bound_lat[%0d]: got %0d want 5", j, lat); end
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        @(posedge clk); #1;
        i = 32'h0000_0100; dir = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; start = 1'b1; i = 32'h0000_0001; dir = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        lat = 4;
        while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL ign_lat: got %0d want 5", lat); end
        n_cmp++; if (o !== 32'h8000_0000) begin n_bad++; $display("FAIL ign_o: got %h want 80000000", o); end
        n_cmp++; if (shamt !== 5'd23) begin n_bad++; $display("FAIL ign_shamt: got %0d want 23", shamt); end
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ign_no_queue: busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int lat, lat2, bc, unstable; logic [31:0] ro; logic [4:0] rs; logic rz;
        do_op(32'h0001_0000, 1'b0, lat, bc, ro, rs, rz);
        n_cmp++; if (rs !== 5'd15) begin n_bad++; $display("FAIL b2b_first_shamt: got %0d want 15", rs); end
        i = 32'h0000_0F00; dir = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; dir = 1'b0;
        lat2 = 0; unstable = 0;
        while (!done && lat2 < 20) begin
            if (o !== 32'h8000_0000 || shamt !== 5'd15) unstable++;
            @(posedge clk); #1;
            lat2++;
        end
        n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL b2b_hold: got %0d unstable cycles want 0", unstable); end
        n_cmp++; if (lat2 !== 5) begin n_bad++; $display("FAIL b2b_lat: got %0d want 5", lat2); end
        n_cmp++; if (o !== 32'h0000_000F) begin n_bad++; $display("FAIL b2b_o: got %h want 0000000f", o); end
        n_cmp++; if (shamt !== 5'd8) begin n_bad++; $display("FAIL b2b_shamt: got %0d want 8", shamt); end
    endtask

    task automatic test_async_reset();
        int lat, bc, seen; logic [31:0] ro; logic [4:0] rs; logic rz;
        @(posedge clk); #1;
        i = 32'h0000_0010; dir = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (o !== 32'h0) begin n_bad++; $display("FAIL arst_o: got %h want 0", o); end
        n_cmp++; if (shamt !== 5'd0) begin n_bad++; $display("FAIL arst_shamt: got %0d want 0", shamt); end
        n_cmp++; if ({zero, busy, done} !== 3'b000) begin n_bad++; $display("FAIL arst_flags: got %b want 000", {zero, busy, done}); end
        seen = 0;
        repeat (2) begin @(posedge clk); #1; if (done) seen++; end
        @(negedge clk); rst_n = 1'b1;
        repeat (6) begin @(posedge clk); #1; if (done || busy) seen++; end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL arst_no_done: got %0d active samples want 0", seen); end
        do_op(32'h0000_4000, 1'b1, lat, bc, ro, rs, rz);
        n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL arst_after_lat: got %0d want 5", lat); end
        n_cmp++; if (ro !== 32'h0000_0001) begin n_bad++; $display("FAIL arst_after_o: got %h want 00000001", ro); end
        n_cmp++; if (rs !== 5'd14) begin n_bad++; $display("FAIL arst_after_shamt: got %0d want 14", rs); end
    endtask

    task automatic test_random();
        int lat, bc, exp_n; logic [31:0] a, exp_o, back; logic d; logic [31:0] ro; logic [4:0] rs; logic rz;
        for (int j = 0; j < 1000; j++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a = a >> $urandom_range(0, 31);
            else a = a << $urandom_range(0, 31);
            if ($urandom_range(0, 63) == 0) a = 32'h0;
            d = 1'($urandom_range(0, 1));
            exp_n = ref_cnt(a, d);
            exp_o = d ? (a >> exp_n) : (a << exp_n);
            do_op(a, d, lat, bc, ro, rs, rz);
            n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL rnd_lat[%0d]: got %0d want 5", j, lat); end
            n_cmp++; if (rs !== 5'(exp_n)) begin n_bad++; $display("FAIL rnd_shamt[%0d] i=%h dir=%b: got %0d want %0d", j, a, d, rs, exp_n); end
            n_cmp++; if (ro !== exp_o) begin n_bad++; $display("FAIL rnd_o[%0d] i=%h dir=%b: got %h want %h", j, a, d, ro, exp_o); end
            n_cmp++; if (rz !== (a == 32'h0)) begin n_bad++; $display("FAIL rnd_zero[%0d]: got %b want %b", j, rz, (a == 32'h0)); end
            if (a != 32'h0) begin
                back = d ? (ro << rs) : (ro >> rs);
                n_cmp++; if (back !== a) begin n_bad++; $display("FAIL rnd_inverse[%0d]: got %h want %h", j, back, a); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_left_normalize();
        test_right_normalize();
        test_zero_operand();
        test_boundaries();
        test_start_ignored();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/barrel_normalizer.md
Name: barrel_normalizer

Overview:
- Multi-cycle inverse of the ALU barrel shifter. Takes a 32-bit word and finds the shift amount that normalizes it.
  - Left normalize: MSB becomes 1 (leading-zero count).
  - Right normalize: LSB becomes 1 (trailing-zero count).
- Resolves one binary stage per clock (16, 8, 4, 2, 1) with a START/BUSY/DONE handshake.
- Sits beside the shifter in the ALU and feeds normalize/count-zeros instructions.
- Invariant: shifting O by SHAMT in the opposite direction reproduces I.

Parameters:
- WIDTH, 32, data width; power of two.
- SW, 5, shift-amount width = log2(WIDTH); also the number of RUN cycles.

Ports:
- CLK  input  1  single clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  request; sampled only when BUSY=0.
- I  input  WIDTH  operand, sampled with START.
- DIR  input  1  0 = normalize left (count leading zeros); 1 = normalize right (count trailing zeros); sampled with START.
- O  output  WIDTH  normalized word (registered).
- SHAMT  output  SW  shift amount applied (registered).
- ZERO  output  1  operand was all-zero (registered).
- BUSY  output  1  operation in progress.
- DONE  output  1  one-cycle pulse; results valid from this cycle.

Behaviour:
- Reset (RST_N low, asynchronous): O=0, SHAMT=0, ZERO=0, BUSY=0, DONE=0, state IDLE, stage index cleared.
  - An operation in flight is aborted; no DONE is produced.
- States:
  - IDLE: START=1 at edge e0 loads working register W<=I, latches DIR, clears working count C, sets stage k=SW-1, sets BUSY=1, moves to RUN.
  - RUN: at each edge one stage of size 2^k is applied.
    - DIR=0: if W[WIDTH-1 -: 2^k]==0 then W<=W<<2^k and C[k]<=1.
    - DIR=1: if W[2^k-1:0]==0 then W<=W>>2^k and C[k]<=1.
    - Vacated bits are zero-filled (logical shift); k decrements each edge.
  - At the edge applying k=0 (e5 for WIDTH=32):
    - O <= final W; SHAMT <= final C; ZERO <= (operand==0).
    - DONE<=1 for exactly one cycle; BUSY<=0; return to IDLE.
- Latency: fixed SW cycles from the START edge to DONE, independent of data.
- O, SHAMT and ZERO change only at completion. They hold their previous values while BUSY and after DONE until the next completion.
- START while BUSY=1 is ignored, with no queuing and no effect on the operation in flight.
- START in the DONE cycle is accepted (BUSY is already 0), giving back-to-back throughput of one result per SW cycles.
- Zero operand: every stage shifts, so O=0, SHAMT=WIDTH-1 (31), ZERO=1, same latency.
- Already-normalized operand (MSB=1 for DIR=0, LSB=1 for DIR=1): SHAMT=0, O=I.
- DIR change mid-operation has no effect; the latched value is used.

Decomposition:
- Shared ALU package holds:
  - state encoding (IDLE, RUN);
  - DIR encoding constants (DIR_LEFT=0, DIR_RIGHT=1), matching the barrel shifter;
  - WIDTH/SW defaults.
- One combinational sub-module, norm_step: inputs W, DIR, k; outputs next W and hit bit.
  - It does the zero-check and conditional shift for stage 2^k.
  - The FSM, counter and output registers stay in barrel_normalizer.

Test Plan:
- DIR=0, I=0x0000_0100, START one cycle -> BUSY high 5 cycles, then DONE pulse with O=0x8000_0000, SHAMT=23, ZERO=0.
- DIR=1, I=0x0000_0100 -> O=0x0000_0001, SHAMT=8, ZERO=0. DIR=1, I=0x8000_0000 -> O=0x0000_0001, SHAMT=31.
- I=0x0000_0000, DIR=0 and DIR=1 -> O=0, SHAMT=31, ZERO=1, DONE after 5 cycles.
- Boundary cases:
  - I=0x8000_0000, DIR=0 -> SHAMT=0, O=0x8000_0000.
  - I=0x0000_0001, DIR=1 -> SHAMT=0.
  - I=0xFFFF_FFFF, either DIR -> SHAMT=0.
- Handshake:
  - START re-pulsed with a different I on cycles 2 and 4 of BUSY -> ignored; results match the first operand.
  - START held high in the DONE cycle -> second DONE exactly 5 cycles later.
  - O/SHAMT stay stable between the two DONE pulses.
- Reset and random check:
  - RST_N driven low asynchronously mid-RUN (cycle 3) -> all outputs 0 immediately, no DONE; after release, a new operation completes correctly.
  - 1000 random I/DIR checked by scoreboard: clz/ctz reference, plus the barrel shifter applied with opposite DIR and SHAMT on O returns I for nonzero I.
